// File: rtl/in_trans.sv
`default_nettype none
// ============================================================================
// Module  : in_trans
// Brief   : Host-side IN transaction engine: IN token, DATA0 capture, ACK,
//           bounded retries on NAK/timeout/error. Optional IN_TRANS_SEND_NAK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module in_trans #(
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        sending,
  output logic        done,
  output logic        success,
  output logic        failure,
  output logic [63:0] data_out,
  input  logic        sent,
  output logic        send_IN,
  output logic        send_ACK,
  output logic        send_NAK,
  input  logic        rec_start,
  input  logic        rec_DATA0,
  input  logic        rec_NAK,
  input  logic        rec_error,
  input  logic [63:0] rec_data
);

  localparam logic [7:0] c_timeout   = 8'(TIMEOUT);
  localparam logic [3:0] c_max_retry = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WAIT_SEND_IN  = 3'd1,
    WAIT_RESPONSE = 3'd2,
    WAIT_SEND_ACK = 3'd3,
    WAIT_SEND_NAK = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_clk_cnt, w_clk_cnt_nxt;
  logic [3:0]  r_to_cnt, w_to_cnt_nxt, w_to_inc;
  logic [3:0]  r_nak_cnt, w_nak_cnt_nxt, w_nak_inc;
  logic [63:0] r_data_out, w_data_nxt;
  logic        w_finish;

  assign w_to_inc  = r_to_cnt + 4'd1;
  assign w_nak_inc = r_nak_cnt + 4'd1;
  assign data_out  = r_data_out;

  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt;
    w_to_cnt_nxt  = r_to_cnt;
    w_nak_cnt_nxt = r_nak_cnt;
    w_data_nxt    = r_data_out;
    w_finish      = 1'b0;
    sending       = 1'b0;
    done          = 1'b0;
    success       = 1'b0;
    failure       = 1'b0;
    send_IN       = 1'b0;
    send_ACK      = 1'b0;
    send_NAK      = 1'b0;
    // Outputs are held low while reset is asserted, whatever the inputs do.
    if (reset_n) begin
      case (r_state)
        IDLE: begin
          if (start) begin
            send_IN       = 1'b1;
            w_to_cnt_nxt  = 4'd0;
            w_nak_cnt_nxt = 4'd0;
            w_state_nxt   = WAIT_SEND_IN;
          end
        end
        WAIT_SEND_IN: begin
          if (!sent) begin
            sending = 1'b1;
          end else begin
            w_clk_cnt_nxt = 8'd0;
            w_state_nxt   = WAIT_RESPONSE;
          end
        end
        WAIT_RESPONSE: begin
          if (rec_start) begin
            w_clk_cnt_nxt = 8'd0;
          end else if (rec_error) begin
            w_to_cnt_nxt = w_to_inc;
            if (w_to_inc == c_max_retry) begin
              w_finish = 1'b1;
              failure  = 1'b1;
            end else begin
`ifdef IN_TRANS_SEND_NAK_EN
              send_NAK    = 1'b1;
              w_state_nxt = WAIT_SEND_NAK;
`else
              send_IN     = 1'b1;
              w_state_nxt = WAIT_SEND_IN;
`endif
            end
          end else if (rec_DATA0) begin
            w_data_nxt  = rec_data;
            send_ACK    = 1'b1;
            w_state_nxt = WAIT_SEND_ACK;
          end else if (rec_NAK) begin
            w_nak_cnt_nxt = w_nak_inc;
            if (w_nak_inc == c_max_retry) begin
              w_finish = 1'b1;
              failure  = 1'b1;
            end else begin
              send_IN     = 1'b1;
              w_state_nxt = WAIT_SEND_IN;
            end
          end else if (r_clk_cnt == c_timeout) begin
            w_to_cnt_nxt = w_to_inc;
            if (w_to_inc == c_max_retry) begin
              w_finish = 1'b1;
              failure  = 1'b1;
            end else begin
              send_IN     = 1'b1;
              w_state_nxt = WAIT_SEND_IN;
            end
          end else begin
            w_clk_cnt_nxt = r_clk_cnt + 8'd1;
          end
        end
        WAIT_SEND_ACK: begin
          if (!sent) begin
            sending = 1'b1;
          end else begin
            w_finish = 1'b1;
            success  = 1'b1;
          end
        end
        WAIT_SEND_NAK: begin
          if (!sent) begin
            sending = 1'b1;
          end else begin
            w_clk_cnt_nxt = 8'd0;
            w_state_nxt   = WAIT_RESPONSE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase

      // A held start in the done cycle launches the next transaction directly.
      if (w_finish) begin
        done = 1'b1;
        if (start) begin
          send_IN       = 1'b1;
          w_to_cnt_nxt  = 4'd0;
          w_nak_cnt_nxt = 4'd0;
          w_state_nxt   = WAIT_SEND_IN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_clk_cnt  <= 8'd0;
      r_to_cnt   <= 4'd0;
      r_nak_cnt  <= 4'd0;
      r_data_out <= 64'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_clk_cnt  <= w_clk_cnt_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_nak_cnt  <= w_nak_cnt_nxt;
      r_data_out <= w_data_nxt;
    end
  end

endmodule
`default_nettype wire
